dmem_burst_reader: RTL and testbench
====================================

# dmem_burst_reader

Burst read engine that drives one read port (EN/ADDR/RDATA) of the GPU's shared 32-bit data BlockRAM. It takes a base address and word count, issues sequential reads that respect the RAM's fixed one-cycle read latency, and buffers the returned words in a small FIFO. Words are then presented on a valid/ready stream with full backpressure. It sits between the data memory and the consumer units (vertex fetch, framebuffer scan-out) on the memory's clock.

## Interface
- DATA_WIDTH, 32, word width; matches the memory.
- ADDR_WIDTH, 15, word address width; matches the memory.
- LEN_WIDTH, 16, burst length counter width.
- FIFO_DEPTH, 4, return buffer entries; power of two, ≥2.

Ports:
- i_CLK  in  1  clock; the memory read port's clock.
- i_RST  in  1  reset; one clock; synchronous, active-high.
- i_START  in  1  starts a burst; sampled only in IDLE.
- i_BASE_ADDR  in  ADDR_WIDTH  first word address.
- i_LEN  in  LEN_WIDTH  number of words to read.
- o_BUSY  out  1  high in ISSUE and DRAIN.
- o_DONE  out  1  one-cycle pulse when the burst completes.
- o_MEM_EN  out  1  memory read enable (registered).
- o_MEM_ADDR  out  ADDR_WIDTH  memory read address (registered).
- i_MEM_RDATA  in  DATA_WIDTH  memory read data; valid the cycle after o_MEM_EN.
- o_DATA  out  DATA_WIDTH  stream data (FIFO head).
- o_VALID  out  1  stream valid.
- i_READY  in  1  stream ready.
- o_LAST  out  1  high with the final word of the burst.

## Operation
- States:
  - IDLE → ISSUE on i_START with i_LEN≠0.
  - IDLE → DONE on i_START with i_LEN=0.
  - ISSUE → DRAIN when the last read issues.
  - DRAIN → DONE when the last beat is accepted.
  - DONE → IDLE unconditionally.
- On start:
  - Latch the address and the issue count (i_LEN).
  - Latch a separate beat count (i_LEN), decremented on each accepted beat.
- Issue rule: a read issues when (reads in flight + FIFO occupancy) < FIFO_DEPTH.
  - This guarantees the FIFO can never overflow. There is no way to stall the memory data.
- A tracking flag set with o_MEM_EN writes i_MEM_RDATA into the FIFO on the following cycle.
- Address increments by 1 per issued read and wraps from 2^ADDR_WIDTH−1 to 0.
- o_LAST = o_VALID & (beat count = 1).
- A beat is accepted when o_VALID & i_READY.
- FIFO write and read in the same cycle are both allowed, including when the FIFO is full and a read frees an entry.
- Once o_VALID is high, o_DATA and o_LAST hold stable until the beat is accepted.
- i_START outside IDLE is ignored.
- i_RST mid-burst:
  - Return to IDLE and empty the FIFO.
  - Discard any in-flight read data; it is not written into the FIFO.
  - o_DONE is not pulsed.
- Reset value of all outputs is 0: o_BUSY, o_DONE, o_MEM_EN, o_MEM_ADDR, o_VALID, o_LAST, o_DATA.

## Timing
- Cycle t: i_START accepted.
- t+1: o_MEM_EN=1, o_MEM_ADDR=base.
- t+2: i_MEM_RDATA valid, FIFO write.
- t+3: first o_VALID.
- Latency from start to first beat is 3 cycles.
- With i_READY held high, one word per cycle is sustained.
  - For LEN=N, the last beat is at t+2+N.
  - o_DONE is at t+3+N.
- Zero length: o_DONE at t+1; o_MEM_EN is never asserted.
- o_DONE is asserted in the cycle after the last beat is accepted. The next i_START is accepted the cycle after o_DONE.
- With i_READY low, issue stops after FIFO_DEPTH words are buffered or in flight. Issue resumes the cycle after a beat is accepted.

## Structure
- Package dmem_pkg holds:
  - Width constants: DMEM_DATA_WIDTH=32, DMEM_ADDR_WIDTH=15.
  - The state encoding: IDLE, ISSUE, DRAIN, DONE.
- dmem_pkg is shared with the memory and its other clients.
- One sub-module: dmem_rd_fifo.
  - Synchronous FIFO with parameters DATA_WIDTH and FIFO_DEPTH.
  - Provides count, full and empty; supports simultaneous push and pop.
- Credit logic and FSM live in the top module.

## Test plan
- Memory preloaded with mem[k]=k; start base=0x10, LEN=4, i_READY=1 → data 0x10..0x13 on consecutive cycles from t+3, o_LAST on 0x13, o_DONE at t+7.
- LEN=0 → o_DONE at t+1, no o_MEM_EN, no o_VALID.
- Base=0x7FFE, LEN=4 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001; data in that order.
- LEN=16, i_READY low for 10 cycles after start → at most 4 o_MEM_EN pulses, o_VALID held with o_DATA=mem[base]; on release all 16 words arrive in order, none lost or duplicated.
- LEN=16, random i_READY → in-order data, exactly one o_LAST, exactly one o_DONE; assert FIFO never overflows.
- i_RST asserted mid-burst with a read in flight → all outputs 0 next cycle. A following burst (base=0x20, LEN=2) returns exactly 0x20, 0x21.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: definitions shared by the GPU data BlockRAM and its clients.
//   DMEM_DATA_WIDTH / DMEM_ADDR_WIDTH : word width and word-address width.
//   ST_*                              : burst reader state encoding.
package dmem_pkg;

  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_ADDR_WIDTH = 15;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/dmem_rd_fifo.sv
// dmem_rd_fifo: synchronous return-data FIFO for the burst reader.
//   i_CLK, i_RST      : clock, synchronous active-high reset (empties FIFO)
//   i_PUSH/i_PUSH_DATA: write one word
//   i_POP             : drop the head word
//   o_HEAD            : head word (valid while o_EMPTY is low)
//   o_COUNT/o_FULL/o_EMPTY : occupancy status
// Push and pop may happen in the same cycle, also when full.
module dmem_rd_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic                          i_PUSH,
  input  logic [DATA_WIDTH-1:0]         i_PUSH_DATA,
  input  logic                          i_POP,
  output logic [DATA_WIDTH-1:0]         o_HEAD,
  output logic [$clog2(FIFO_DEPTH):0]   o_COUNT,
  output logic                          o_FULL,
  output logic                          o_EMPTY
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  // Storage is not reset; the head is only meaningful while non-empty.
  always_ff @(posedge i_CLK) begin
    if (i_PUSH) mem[wr_ptr] <= i_PUSH_DATA;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (i_PUSH) wr_ptr <= wr_ptr + AW'(1);
      if (i_POP)  rd_ptr <= rd_ptr + AW'(1);
      case ({i_PUSH, i_POP})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_HEAD  = mem[rd_ptr];
  assign o_COUNT = count;
  assign o_FULL  = (count == CW'(FIFO_DEPTH));
  assign o_EMPTY = (count == '0);

endmodule

// File: rtl/dmem_burst_reader.sv
// dmem_burst_reader: sequential burst reads from the shared data BlockRAM,
// returned on a valid/ready stream with full backpressure.
//   i_CLK, i_RST              : memory clock, synchronous active-high reset
//   i_START/i_BASE_ADDR/i_LEN : burst request, sampled only in IDLE
//   o_BUSY                    : burst in progress (ISSUE or DRAIN)
//   o_DONE                    : one-cycle completion pulse
//   o_MEM_EN/o_MEM_ADDR       : registered read request, data one cycle later
//   i_MEM_RDATA               : read data from the memory
//   o_DATA/o_VALID/i_READY    : output stream; o_LAST marks the final word
module dmem_burst_reader
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_START,
  input  logic [ADDR_WIDTH-1:0] i_BASE_ADDR,
  input  logic [LEN_WIDTH-1:0]  i_LEN,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_MEM_EN,
  output logic [ADDR_WIDTH-1:0] o_MEM_ADDR,
  input  logic [DATA_WIDTH-1:0] i_MEM_RDATA,
  output logic [DATA_WIDTH-1:0] o_DATA,
  output logic                  o_VALID,
  input  logic                  i_READY,
  output logic                  o_LAST
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW1 = CW + 1;

  logic [1:0]            state;
  logic [LEN_WIDTH-1:0]  issue_left;
  logic [LEN_WIDTH-1:0]  beat_left;
  logic                  rd_pend;
  logic                  beat;
  logic                  issue;
  logic [CW1-1:0]        committed;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  dmem_rd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_CLK       (i_CLK),
    .i_RST       (i_RST),
    .i_PUSH      (rd_pend),
    .i_PUSH_DATA (i_MEM_RDATA),
    .i_POP       (beat),
    .o_HEAD      (fifo_head),
    .o_COUNT     (fifo_count),
    .o_FULL      (fifo_full),
    .o_EMPTY     (fifo_empty)
  );

  assign o_VALID = ~fifo_empty;
  assign beat    = o_VALID & i_READY;
  assign o_DATA  = o_VALID ? fifo_head : '0;
  assign o_LAST  = o_VALID & (beat_left == LEN_WIDTH'(1));
  assign o_BUSY  = (state == ST_ISSUE) | (state == ST_DRAIN);
  assign o_DONE  = (state == ST_DONE);

  // Entries that will occupy the FIFO after this edge: buffered words plus
  // the read returning now plus the read issued last cycle, minus a pop.
  // Counting the pop lets issue resume the cycle after a beat is accepted.
  always_comb begin
    committed = CW1'(fifo_count) + CW1'(rd_pend) + CW1'(o_MEM_EN) - CW1'(beat);
  end

  assign issue = (state == ST_ISSUE) && (issue_left != '0) &&
                 (committed < CW1'(FIFO_DEPTH));

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state      <= ST_IDLE;
      o_MEM_EN   <= 1'b0;
      o_MEM_ADDR <= '0;
      issue_left <= '0;
      beat_left  <= '0;
      rd_pend    <= 1'b0;
    end else begin
      // Credit accounting makes a write into a full FIFO without a pop impossible.
      assert (!(fifo_full && rd_pend && !beat));
      rd_pend  <= o_MEM_EN;
      o_MEM_EN <= 1'b0;
      if (beat) beat_left <= beat_left - LEN_WIDTH'(1);
      case (state)
        ST_IDLE: begin
          if (i_START) begin
            beat_left <= i_LEN;
            if (i_LEN == '0) begin
              state <= ST_DONE;
            end else begin
              // First read goes out on the start edge to meet the 3-cycle latency.
              state      <= ST_ISSUE;
              o_MEM_EN   <= 1'b1;
              o_MEM_ADDR <= i_BASE_ADDR;
              issue_left <= i_LEN - LEN_WIDTH'(1);
            end
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            o_MEM_EN   <= 1'b1;
            o_MEM_ADDR <= o_MEM_ADDR + ADDR_WIDTH'(1);
            issue_left <= issue_left - LEN_WIDTH'(1);
          end
          if ((issue_left == '0) || (issue && (issue_left == LEN_WIDTH'(1))))
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (beat && (beat_left == LEN_WIDTH'(1))) state <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_burst_reader.sv
// tb_dmem_burst_reader: directed bench for dmem_burst_reader with a
// scoreboard of expected read addresses and stream words. The memory model
// returns mem[k] = k one cycle after a read enable.
module tb_dmem_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [14:0] base;
  logic [15:0] len;
  logic        busy, done, mem_en, valid, ready, last;
  logic [14:0] mem_addr;
  logic [31:0] mem_rdata, data;

  always #5 clk = ~clk;

  dmem_burst_reader #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (15),
    .LEN_WIDTH  (16),
    .FIFO_DEPTH (4)
  ) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_START     (start),
    .i_BASE_ADDR (base),
    .i_LEN       (len),
    .o_BUSY      (busy),
    .o_DONE      (done),
    .o_MEM_EN    (mem_en),
    .o_MEM_ADDR  (mem_addr),
    .i_MEM_RDATA (mem_rdata),
    .o_DATA      (data),
    .o_VALID     (valid),
    .i_READY     (ready),
    .o_LAST      (last)
  );

  // Memory model: mem[k] = k; garbage when not enabled.
  always @(posedge clk) mem_rdata <= mem_en ? {17'b0, mem_addr} : 32'hDEADBEEF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard and per-burst statistics, owned by the monitor.
  logic [14:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int start_cyc, n_en, first_en_cyc, n_valid, first_valid_cyc;
  int n_beats, n_last, last_cyc, n_done, done_cyc, outstanding, max_out;
  logic        held;
  logic [31:0] held_data;
  logic        held_last;

  always @(negedge clk) begin
    if (rst) begin
      exp_addr.delete();
      exp_data.delete();
      n_en = 0; n_valid = 0; n_beats = 0; n_last = 0; n_done = 0;
      outstanding = 0; max_out = 0; held = 1'b0;
      first_en_cyc = -1; first_valid_cyc = -1; last_cyc = -1; done_cyc = -1;
    end else begin
      if (start && !busy && !done) begin
        start_cyc = cyc;
        n_en = 0; n_valid = 0; n_beats = 0; n_last = 0; n_done = 0;
        outstanding = 0; max_out = 0;
        first_en_cyc = -1; first_valid_cyc = -1; last_cyc = -1; done_cyc = -1;
        for (int k = 0; k < int'(len); k++) begin
          logic [14:0] a;
          a = base + 15'(k);
          exp_addr.push_back(a);
          exp_data.push_back({17'b0, a});
        end
      end
      if (mem_en) begin
        n_en++;
        outstanding++;
        if (first_en_cyc < 0) first_en_cyc = cyc;
        if (exp_addr.size() > 0) check("mem_addr", mem_addr, exp_addr.pop_front());
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (held && !valid) check("hold_valid", valid, 1);
      if (valid) begin
        n_valid++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (held) begin
          check("hold_data", data, held_data);
          check("hold_last", last, held_last);
        end
        if (ready) begin
          n_beats++;
          outstanding--;
          held = 1'b0;
          if (exp_data.size() > 0) begin
            check("beat_data", data, exp_data[0]);
            check("beat_last", last, exp_data.size() == 1);
            void'(exp_data.pop_front());
          end
          if (last) begin
            n_last++;
            last_cyc = cyc;
          end
        end else begin
          held      = 1'b1;
          held_data = data;
          held_last = last;
        end
      end else begin
        held = 1'b0;
      end
      if (outstanding > max_out) max_out = outstanding;
    end
  end

  task automatic start_burst(input logic [14:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    start = 1'b1;
    base  = b;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
    check({tag, "_mem_en"},   mem_en,   0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_valid"},    valid,    0);
    check({tag, "_last"},     last,     0);
    check({tag, "_data"},     data,     0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; len = '0; ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic burst, ready held high.
    ready = 1'b1;
    start_burst(15'h0010, 16'd4);
    wait_done(100);
    check("t1_first_en",    first_en_cyc,    start_cyc + 1);
    check("t1_first_valid", first_valid_cyc, start_cyc + 3);
    check("t1_last_cyc",    last_cyc,        start_cyc + 6);
    check("t1_done_cyc",    done_cyc,        start_cyc + 7);
    check("t1_valid_cycles", n_valid, 4);
    check("t1_beats",  n_beats, 4);
    check("t1_lasts",  n_last,  1);
    check("t1_reads",  n_en,    4);
    check("t1_dones",  n_done,  1);
    check("t1_left",   exp_data.size(), 0);

    // Zero length.
    start_burst(15'h0055, 16'd0);
    wait_done(20);
    check("t2_done_cyc", done_cyc, start_cyc + 1);
    check("t2_reads",    n_en,     0);
    check("t2_valid",    n_valid,  0);
    check("t2_dones",    n_done,   1);

    // Address wrap.
    start_burst(15'h7FFE, 16'd4);
    wait_done(100);
    check("t3_beats",     n_beats, 4);
    check("t3_lasts",     n_last,  1);
    check("t3_dones",     n_done,  1);
    check("t3_addr_left", exp_addr.size(), 0);

    // Backpressure: ready low for 10 cycles after start.
    ready = 1'b0;
    start_burst(15'h0100, 16'd16);
    repeat (9) @(posedge clk);
    @(negedge clk); #1;
    check("t4_reads_stalled", n_en,  4);
    check("t4_valid_held",    valid, 1);
    check("t4_data_held",     data,  32'h0000_0100);
    @(posedge clk); #1;
    ready = 1'b1;
    wait_done(200);
    check("t4_beats",   n_beats, 16);
    check("t4_lasts",   n_last,  1);
    check("t4_dones",   n_done,  1);
    check("t4_max_out", max_out, 4);
    check("t4_left",    exp_data.size(), 0);

    // Random backpressure.
    start_burst(15'h0300, 16'd16);
    for (int i = 0; i < 600 && n_done == 0; i++) begin
      @(posedge clk); #1;
      ready = 1'($urandom_range(0, 1));
    end
    ready = 1'b1;
    repeat (3) @(posedge clk);
    check("t5_beats",       n_beats, 16);
    check("t5_lasts",       n_last,  1);
    check("t5_dones",       n_done,  1);
    check("t5_no_overflow", max_out <= 4, 1);
    check("t5_left",        exp_data.size(), 0);

    // Reset mid-burst with a read in flight.
    start_burst(15'h0000, 16'd8);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_outputs_zero("midrst");
    repeat (5) @(posedge clk);
    check("t6_no_done",  n_done,  0);
    check("t6_no_valid", n_valid, 0);
    start_burst(15'h0020, 16'd2);
    wait_done(50);
    check("t6_beats", n_beats, 2);
    check("t6_lasts", n_last,  1);
    check("t6_dones", n_done,  1);
    check("t6_left",  exp_data.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
